// File: rtl/lif_pkg.sv
// ============================================================================
// Module      : lif_pkg
// Description : Shared constants and FSM state encoding for the LIF spike path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lif_pkg;

   localparam int DEFAULT_CURRENT_W   = 4;
   localparam int DEFAULT_WINDOW_LOG2 = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } lif_state_e;

endpackage

`default_nettype wire

// File: rtl/spike_window_counter.sv
// ============================================================================
// Module      : spike_window_counter
// Description : Window cycle counter and spike accumulator for rate decoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_window_counter
   import lif_pkg::*;
#(
   parameter int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   input  logic                 spike,
   output logic [WINDOW_LOG2:0] count,
   output logic                 window_done
);

   logic [WINDOW_LOG2-1:0] win_cnt;
   logic [WINDOW_LOG2:0]   acc;
   logic                   last_cycle;

   assign last_cycle  = &win_cnt;
   // count includes the current cycle's spike so the final window cycle is counted
   assign count       = acc + {{WINDOW_LOG2{1'b0}}, spike};
   assign window_done = run & last_cycle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt <= '0;
         acc     <= '0;
      end else if (!run) begin
         win_cnt <= '0;
         acc     <= '0;
      end else begin
         win_cnt <= win_cnt + 1'b1;
         acc     <= last_cycle ? '0 : count;
      end
   end

endmodule

`default_nettype wire

// File: rtl/spike_rate_decoder.sv
// ============================================================================
// Module      : spike_rate_decoder
// Description : Windowed spike-count to rate decoder with valid/ready output.
//               Optional rounded smoothing: SPIKE_RATE_DECODER_SMOOTH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_rate_decoder
   import lif_pkg::*;
#(
   parameter int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2,
   parameter int OUT_W       = DEFAULT_CURRENT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             spike,
   input  logic             enable,
   output logic [OUT_W-1:0] rate,
   output logic             rate_valid,
   input  logic             rate_ready,
   output logic             overrun,
   output logic             busy
);

   localparam int             SHIFT   = WINDOW_LOG2 - OUT_W;
   localparam logic [0:0]     S_IDLE  = IDLE;
   localparam logic [0:0]     S_COUNT = COUNT;
   localparam logic [OUT_W:0] SAT_MAX = {1'b0, {OUT_W{1'b1}}};

   logic [0:0]         state;
   logic               run;
   logic               window_done;
   logic [WINDOW_LOG2:0] count;
   logic [WINDOW_LOG2:0] shifted;
   logic [OUT_W:0]     scaled;
   logic [OUT_W-1:0]   result;
   logic [OUT_W-1:0]   load_val;

   assign busy = (state == S_COUNT);
   // a low enable in COUNT aborts this very cycle, so it is never counted
   assign run  = busy & enable;

   spike_window_counter #(
      .WINDOW_LOG2 (WINDOW_LOG2)
   ) u_counter (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .spike       (spike),
      .count       (count),
      .window_done (window_done)
   );

   assign shifted = count >> SHIFT;
   assign scaled  = shifted[OUT_W:0];
   assign result  = (scaled > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : scaled[OUT_W-1:0];

`ifdef SPIKE_RATE_DECODER_SMOOTH_EN
   logic           first_done;
   logic [OUT_W:0] avg_sum;

   assign avg_sum  = {1'b0, rate} + {1'b0, result} + {{OUT_W{1'b0}}, 1'b1};
   assign load_val = first_done ? avg_sum[OUT_W:1] : result;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_done <= 1'b0;
      end else if (window_done) begin
         first_done <= 1'b1;
      end
   end
`else
   assign load_val = result;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         rate       <= '0;
         rate_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (state == S_IDLE) begin
            if (enable) state <= S_COUNT;
         end else begin
            if (!enable) state <= S_IDLE;
         end

         overrun <= window_done & rate_valid & ~rate_ready;

         if (window_done) begin
            rate       <= load_val;
            rate_valid <= 1'b1;
         end else if (rate_valid && rate_ready) begin
            rate_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
// ============================================================================
// Module      : tb_spike_rate_decoder
// Description : Directed self-checking bench for spike_rate_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spike_rate_decoder;

   logic       clk;
   logic       rst_n;
   logic       spike;
   logic       enable;
   logic [3:0] rate;
   logic       rate_valid;
   logic       rate_ready;
   logic       overrun;
   logic       busy;

   int n_total;
   int n_bad;

   spike_rate_decoder #(
      .WINDOW_LOG2 (4),
      .OUT_W       (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spike      (spike),
      .enable     (enable),
      .rate       (rate),
      .rate_valid (rate_valid),
      .rate_ready (rate_ready),
      .overrun    (overrun),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // pat[k] drives window cycle k; returns just after the load edge
   task automatic feed_window(input logic [15:0] pat, input bit chk_drop, input logic new_ready);
      for (int k = 0; k < 16; k++) begin
         spike = pat[k];
         tick();
         if (k == 0) begin
            if (chk_drop) check("valid_drop", {31'd0, rate_valid}, 32'd0);
            rate_ready = new_ready;
         end
      end
      spike = 1'b0;
   endtask

   initial begin
      n_total    = 0;
      n_bad      = 0;
      rst_n      = 1'b0;
      spike      = 1'b0;
      enable     = 1'b0;
      rate_ready = 1'b0;
      repeat (3) tick();
      check("rst_rate",    {28'd0, rate},       32'd0);
      check("rst_valid",   {31'd0, rate_valid}, 32'd0);
      check("rst_overrun", {31'd0, overrun},    32'd0);
      check("rst_busy",    {31'd0, busy},       32'd0);
      rst_n = 1'b1;
      tick();

      // saturating window: every cycle spikes
      enable     = 1'b1;
      spike      = 1'b1;
      rate_ready = 1'b1;
      repeat (16) tick();
      check("sat_not_yet", {31'd0, rate_valid}, 32'd0);
      check("sat_busy",    {31'd0, busy},       32'd1);
      tick();
      check("sat_valid", {31'd0, rate_valid}, 32'd1);
      check("sat_rate",  {28'd0, rate},       32'd15);

      feed_window(16'h5555, 1'b1, 1'b1);
      check("alt_valid", {31'd0, rate_valid}, 32'd1);
      check("alt_rate",  {28'd0, rate},       32'd8);

      feed_window(16'h8000, 1'b1, 1'b1);
      check("last_valid", {31'd0, rate_valid}, 32'd1);
      check("last_rate",  {28'd0, rate},       32'd1);

      // two loads with the consumer stalled
      feed_window(16'h1111, 1'b1, 1'b0);
      check("ovr1_rate",    {28'd0, rate},       32'd4);
      check("ovr1_valid",   {31'd0, rate_valid}, 32'd1);
      check("ovr1_overrun", {31'd0, overrun},    32'd0);
      feed_window(16'h003F, 1'b0, 1'b0);
      check("ovr2_rate",    {28'd0, rate},       32'd6);
      check("ovr2_valid",   {31'd0, rate_valid}, 32'd1);
      check("ovr2_overrun", {31'd0, overrun},    32'd1);
      tick();
      check("ovr_pulse_end", {31'd0, overrun},    32'd0);
      check("ovr_held",      {31'd0, rate_valid}, 32'd1);
      rate_ready = 1'b1;
      tick();
      check("ovr_taken", {31'd0, rate_valid}, 32'd0);
      rate_ready = 1'b0;

      enable = 1'b0;
      tick();
      check("idle_busy", {31'd0, busy}, 32'd0);

      enable = 1'b1;
      tick();
      feed_window(16'h0003, 1'b0, 1'b0);
      check("pre_abort_rate",  {28'd0, rate},       32'd2);
      check("pre_abort_valid", {31'd0, rate_valid}, 32'd1);

      // abort at window cycle 9 after five spikes
      for (int k = 0; k < 9; k++) begin
         spike = (k < 5);
         tick();
      end
      spike  = 1'b0;
      enable = 1'b0;
      tick();
      check("abort_busy",  {31'd0, busy},       32'd0);
      check("abort_rate",  {28'd0, rate},       32'd2);
      check("abort_valid", {31'd0, rate_valid}, 32'd1);
      repeat (20) tick();
      check("abort_noload", {28'd0, rate},    32'd2);
      check("abort_noovr",  {31'd0, overrun}, 32'd0);

      enable = 1'b1;
      tick();
      feed_window(16'h0001, 1'b0, 1'b0);
      check("restart_rate",    {28'd0, rate},    32'd1);
      check("restart_overrun", {31'd0, overrun}, 32'd1);

      // asynchronous reset mid-window
      spike = 1'b1;
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      check("arst_rate",    {28'd0, rate},       32'd0);
      check("arst_valid",   {31'd0, rate_valid}, 32'd0);
      check("arst_busy",    {31'd0, busy},       32'd0);
      check("arst_overrun", {31'd0, overrun},    32'd0);
      spike  = 1'b0;
      enable = 1'b0;
      tick();
      rst_n  = 1'b1;
      enable = 1'b1;
      tick();
      feed_window(16'h0FFF, 1'b0, 1'b1);
      check("win12_rate", {28'd0, rate}, 32'd12);
      feed_window(16'h000F, 1'b1, 1'b1);
`ifdef SPIKE_RATE_DECODER_SMOOTH_EN
      check("win4_rate", {28'd0, rate}, 32'd8);
`else
      check("win4_rate", {28'd0, rate}, 32'd4);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receive end of the neuron's spike interface: converts a 1-bit spike train back into a multi-bit rate value, the inverse of the current-to-spike LIF path.
- Counts spikes over a fixed window of 2^WINDOW_LOG2 cycles, scales and saturates the count to OUT_W bits, and presents the result on a valid/ready output.
- Sits downstream of a lif neuron or a spike bus, feeding a readout or the next layer's current input.

Parameters:
- WINDOW_LOG2, 4, window length is 2^WINDOW_LOG2 clk cycles; legal range is OUT_W..8.
- OUT_W, 4, width of the decoded rate; matches the neuron current input width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- spike  input  1  spike train, sampled each clk; 1 means one spike
- enable  input  1  high runs decoding; low aborts the window and idles
- rate  output  OUT_W  decoded rate of the last completed window
- rate_valid  output  1  rate holds an unconsumed result
- rate_ready  input  1  consumer accepts rate when high with rate_valid
- overrun  output  1  one-cycle pulse: an unconsumed result was overwritten
- busy  output  1  high while in COUNT

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: rate=0, rate_valid=0, overrun=0, busy=0, FSM=IDLE, window counter=0, spike count=0.
- FSM states and transitions:
  - IDLE to COUNT when enable=1. The first COUNT cycle is window cycle 0.
  - COUNT: the window counter (WINDOW_LOG2 bits) increments each cycle. The spike count (WINDOW_LOG2+1 bits) adds spike each cycle.
  - At window cycle 2^WINDOW_LOG2-1 (counter all ones):
    - A spike on that cycle is included in the result.
    - The result loads into rate on the next edge.
    - The counter wraps to 0 and the count clears.
    - The FSM stays in COUNT, so windows run back-to-back with no gap cycles.
  - COUNT to IDLE when enable=0, on any cycle including the final window cycle. The partial count is discarded and no result is produced. rate and rate_valid are retained.
- Arithmetic:
  - result = count >> (WINDOW_LOG2-OUT_W).
  - If result exceeds 2^OUT_W-1, it saturates to 2^OUT_W-1.
  - Defaults: 16 spikes in 16 cycles gives 15; 0 spikes gives 0.
- Latency: rate and rate_valid update one cycle after the final window cycle.
- Handshake:
  - A transfer occurs on an edge where rate_valid && rate_ready.
  - rate_valid clears after a transfer unless a new result loads on the same edge; then it stays 1 with new data.
  - rate is stable while rate_valid=1 and no new result loads.
  - rate_ready while rate_valid=0 has no effect.
- Overrun: a new result loading while rate_valid=1 and rate_ready=0 overwrites rate and pulses overrun for exactly one cycle. Newest data wins.
- busy equals (FSM==COUNT).
- Reset mid-window: all state returns to reset values immediately. No partial result is emitted.

Optional Feature:
- Macro: SPIKE_RATE_DECODER_SMOOTH_EN.
- With the macro defined: the loaded value is (rate + result + 1) >> 1, computed with an OUT_W+1-bit intermediate. This is a rounded first-order average with the previous rate. The first window after reset loads result directly; a 1-bit flag tracks "first". An enable abort does not reset the flag.
- Without the macro: rate = result, and the flag logic is absent.

Decomposition:
- Shared package (lif_pkg): constants DEFAULT_CURRENT_W=4 and DEFAULT_WINDOW_LOG2=4, and the FSM state enum {IDLE, COUNT}.
- Natural sub-module: spike_window_counter. It holds the window counter and spike accumulator, and outputs count plus a window_done pulse. The top holds the FSM, scaling/saturation, output register and handshake.

Test Plan:
- Reset, then enable=1 with spike=1 every cycle, rate_ready=1: the first rate_valid appears 17 cycles after enable rises, rate=15 (saturated). Thereafter a new result every 16 cycles.
- spike alternating 1,0 for one 16-cycle window: rate=8; rate_valid pulses 1 cycle with rate_ready=1.
- Spike only on window cycle 15 (last): rate=1, which proves last-cycle inclusion.
- rate_ready=0 for two windows (counts 4 then 6): overrun pulses once at the second load; rate=6; rate_valid held. Then rate_ready=1 for one cycle: rate_valid drops.
- enable drops at window cycle 9 after 5 spikes: no load, busy=0, prior rate/rate_valid unchanged. Re-enable restarts at cycle 0.
- Assert rst_n=0 asynchronously mid-window with rate_valid=1: all outputs are 0 before the next clk edge. With SMOOTH_EN defined, windows of 12 then 4 give rate 12 then 8.
